text_memory_arbiter: RTL
========================

TEXT_MEMORY_ARBITER -- requirements
Module: text_memory_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 4, max consecutive cycles a pending fetch may lose to data before forced fetch grant (legal 1..15).
REQ-002 SHALL have ports (clock and reset first); single clock domain, reset asynchronous active-high:
  clock  in  1  rising-edge clock
  reset  in  1  asynchronous active-high reset
  fetch_req  in  1  instruction-fetch request
  fetch_addr  in  TEXT_BITS-2  fetch word address
  fetch_gnt  out  1  fetch request accepted this cycle
  fetch_rvalid  out  1  fetch_rdata valid
  fetch_rdata  out  32  fetched word
  data_req  in  1  data-side (load from text) request
  data_addr  in  TEXT_BITS-2  data word address
  data_gnt  out  1  data request accepted this cycle
  data_rvalid  out  1  data_rdata valid
  data_rdata  out  32  read word
  mem_address  out  TEXT_BITS-2  word address to text memory
  mem_q  in  32  combinational read data from text memory

Function
REQ-003 SHALL grant at most one memory access per cycle; gnt outputs are combinational from req, state and counter.
REQ-004 SHALL drive mem_address = data_addr when data granted, else fetch_addr.
REQ-005 SHALL register mem_q at the granting edge; rvalid and rdata of the granted port asserted exactly one cycle after gnt, for one cycle.
REQ-006 Non-granted port's rvalid SHALL be 0; its rdata SHALL hold last value.
REQ-007 Requester SHALL hold req and addr stable until gnt; addr may change the cycle after gnt; back-to-back grants to one port every cycle SHALL be supported.
REQ-008 Conflict (both req): data wins unless starve_cnt == STARVE_LIMIT, then fetch wins.
REQ-009 starve_cnt (4-bit): increment when fetch_req && !fetch_gnt, saturating at STARVE_LIMIT; clear to 0 on any fetch_gnt or when fetch_req low.
REQ-010 Single requester SHALL be granted in the same cycle, regardless of starve_cnt.
REQ-011 Grant owner per cycle SHALL be one of NONE, FETCH, DATA, FETCH_BUF; registered owner selects which rvalid fires next cycle.
REQ-012 Same address on both ports, same cycle: SHALL be treated as a conflict (no merging).

Reset
REQ-013 On reset: fetch_rvalid=0, data_rvalid=0, fetch_rdata=0, data_rdata=0, starve_cnt=0, registered owner=NONE, fetch buffer invalid.
REQ-014 Reset asserted with a grant outstanding SHALL suppress the pending rvalid; no response after reset release for pre-reset grants.
REQ-015 gnt outputs SHALL be 0 while reset asserted.

Configuration
REQ-016 Macro TEXT_ARB_FETCH_BUFFER_EN SHALL include a one-entry fetch buffer (valid, tag, word).
REQ-017 With macro: every memory fetch grant writes tag=fetch_addr, word=mem_q, valid=1; a fetch with valid && tag==fetch_addr is granted (owner FETCH_BUF) without using the memory port, data request granted same cycle, starve_cnt cleared; response latency unchanged (1 cycle).
REQ-018 Without macro: no buffer state; all fetches use the memory port; FETCH_BUF never occurs.

Structure
REQ-019 Package text_arb_pkg SHALL hold the word-address typedef (TEXT_BITS-2 bits), the owner enum {NONE, FETCH, DATA, FETCH_BUF} and the starve counter width constant.
REQ-020 The fetch buffer SHALL be sub-module text_arb_fetch_buffer (lookup hit combinational, fill on clock), instantiated only under TEXT_ARB_FETCH_BUFFER_EN.

Verification
REQ-021 Fetch only, fetch_addr=0x010, mem word 0x00500093 -> fetch_gnt same cycle, fetch_rvalid next cycle with 0x00500093, data_rvalid=0.
REQ-022 Both req continuously, STARVE_LIMIT=4 -> data granted 4 cycles, fetch granted 5th cycle, pattern repeats.
REQ-023 Back-to-back data reads 0x004,0x005,0x006 -> three consecutive data_rvalid with matching words, no gaps.
REQ-024 Reset asserted the cycle after data_gnt for 0x020 -> data_rvalid stays 0, all rdata read 0 after reset.
REQ-025 With TEXT_ARB_FETCH_BUFFER_EN: fetch 0x030 twice, second concurrent with data_req 0x040 -> both granted same cycle, next cycle both rvalid, fetch word from buffer; without macro -> data wins, fetch one cycle later.

Source files
------------

// File: rtl/text_arb_pkg.sv
// Shared types for the text-memory arbiter: word-address type, grant owner
// encoding and starvation counter width.
package text_arb_pkg;

    localparam int TEXT_BITS = 14;
    localparam int WORD_BITS = TEXT_BITS - 2;
    localparam int STARVE_W  = 4;

    typedef logic [WORD_BITS-1:0] word_addr_t;

    // Who owns the access granted this cycle; FETCH_BUF means the fetch was
    // served from the one-entry buffer instead of the memory port.
    typedef enum logic [1:0] {
        NONE      = 2'd0,
        FETCH     = 2'd1,
        DATA      = 2'd2,
        FETCH_BUF = 2'd3
    } owner_e;

endpackage

// File: rtl/text_arb_fetch_buffer.sv
// One-entry fetch buffer: remembers the last word fetched through the memory
// port so a repeated fetch can be served while data uses the port.
module text_arb_fetch_buffer
    import text_arb_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  word_addr_t  lookup_addr,
    output logic        hit,
    output logic [31:0] word,
    input  logic        fill_en,
    input  word_addr_t  fill_addr,
    input  logic [31:0] fill_word
);

    logic        valid_reg;
    word_addr_t  tag_reg;
    logic [31:0] word_reg;

    // Lookup is purely combinational so the arbiter can grant in the same cycle.
    always_comb begin
        hit  = valid_reg && (tag_reg == lookup_addr);
        word = word_reg;
    end

    // Fill on every memory-port fetch grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_reg <= 1'b0;
            tag_reg   <= '0;
            word_reg  <= '0;
        end else if (fill_en) begin
            valid_reg <= 1'b1;
            tag_reg   <= fill_addr;
            word_reg  <= fill_word;
        end
    end

endmodule

// File: rtl/text_memory_arbiter.sv
// Arbitrates the single text-memory read port between instruction fetch and
// data loads. Data normally wins; fetch is forced through after STARVE_LIMIT
// lost cycles. Define TEXT_ARB_FETCH_BUFFER_EN to add a one-entry fetch
// buffer that lets a repeated fetch complete alongside a data access.
module text_memory_arbiter
    import text_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
)(
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_req,
    input  word_addr_t  fetch_addr,
    output logic        fetch_gnt,
    output logic        fetch_rvalid,
    output logic [31:0] fetch_rdata,
    input  logic        data_req,
    input  word_addr_t  data_addr,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    output word_addr_t  mem_address,
    input  logic [31:0] mem_q
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_cnt_reg, starve_cnt_next;
    owner_e              owner_reg, owner_next;
    logic                data_pend_reg;
    logic [31:0]         fetch_rdata_reg;
    logic [31:0]         data_rdata_reg;
    logic                buf_hit;
    logic [31:0]         buf_word;

`ifdef TEXT_ARB_FETCH_BUFFER_EN
    logic lookup_hit;

    text_arb_fetch_buffer u_fetch_buffer (
        .clock       (clock),
        .reset       (reset),
        .lookup_addr (fetch_addr),
        .hit         (lookup_hit),
        .word        (buf_word),
        .fill_en     (owner_next == FETCH),
        .fill_addr   (fetch_addr),
        .fill_word   (mem_q)
    );

    assign buf_hit = fetch_req && lookup_hit;
`else
    assign buf_hit  = 1'b0;
    assign buf_word = '0;
`endif

    // Grant decision: buffer hit frees the port for data; otherwise data wins
    // a conflict unless fetch has starved for STARVE_LIMIT cycles.
    always_comb begin
        fetch_gnt  = 1'b0;
        data_gnt   = 1'b0;
        owner_next = NONE;
        if (!reset) begin
            if (buf_hit) begin
                fetch_gnt = 1'b1;
                data_gnt  = data_req;
            end else if (fetch_req && data_req) begin
                if (starve_cnt_reg == LIMIT) fetch_gnt = 1'b1;
                else                         data_gnt  = 1'b1;
            end else begin
                fetch_gnt = fetch_req;
                data_gnt  = data_req;
            end
            if (buf_hit)        owner_next = FETCH_BUF;
            else if (fetch_gnt) owner_next = FETCH;
            else if (data_gnt)  owner_next = DATA;
        end
    end

    // Port address follows the data side only when data actually owns it.
    assign mem_address = data_gnt ? data_addr : fetch_addr;

    // Starvation counter: counts consecutive cycles a pending fetch lost.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!fetch_req || fetch_gnt)  starve_cnt_next = '0;
        else if (starve_cnt_reg < LIMIT) starve_cnt_next = starve_cnt_reg + 1'b1;
    end

    // Capture read data at the granting edge; rvalid follows one cycle later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt_reg  <= '0;
            owner_reg       <= NONE;
            data_pend_reg   <= 1'b0;
            fetch_rdata_reg <= '0;
            data_rdata_reg  <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            owner_reg      <= owner_next;
            data_pend_reg  <= data_gnt;
            if (owner_next == FETCH)     fetch_rdata_reg <= mem_q;
            if (owner_next == FETCH_BUF) fetch_rdata_reg <= buf_word;
            if (data_gnt)                data_rdata_reg  <= mem_q;
        end
    end

    // Registered owner selects the fetch response; data may ride alongside a
    // buffer hit, so its response is tracked by its own flag.
    assign fetch_rvalid = (owner_reg == FETCH) || (owner_reg == FETCH_BUF);
    assign data_rvalid  = data_pend_reg;
    assign fetch_rdata  = fetch_rdata_reg;
    assign data_rdata   = data_rdata_reg;

endmodule
